// File: rtl/out_arb_pkg.sv
// Shared constants and FSM state type for the output arbiter.
package out_arb_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned GAP_DEF   = 2;
   localparam int unsigned CNT_W     = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/out_fifo.sv
// Synchronous single-clock byte FIFO with full/empty/count status.
module out_fifo
   import out_arb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned W     = DATA_W
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             push_data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/out_arb.sv
// Two-requester round-robin arbiter feeding a FIFO and a toggle-strobe output port.
module out_arb
   import out_arb_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned GAP   = GAP_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic [DATA_W-1:0] out_dat,
   output logic              out_ctl,
   output logic              busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    hold_q, hold_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic                ctl_q, ctl_d;
   logic                last_q, last_d;
   logic                grant_c;
   logic                push_c;
   logic                pop_c;
   logic [DATA_W-1:0]   push_data_c;
   logic [DATA_W-1:0]   pop_data;
   logic                full;
   logic                empty;
   logic [CW-1:0]       count;

   // Round-robin grant: lone requester wins, otherwise the one not served last.
   always_comb begin
      grant_c = ~last_q;
      if (req0_valid ^ req1_valid) grant_c = req1_valid;
   end

   assign req0_ready  = !full && !grant_c;
   assign req1_ready  = !full && grant_c;
   assign push_c      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign push_data_c = grant_c ? req1_data : req0_data;
   assign last_d      = push_c ? grant_c : last_q;

   out_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_c),
      .push_data_i (push_data_c),
      .pop_i       (pop_c),
      .pop_data_o  (pop_data),
      .full_o      (full),
      .empty_o     (empty),
      .count_o     (count)
   );

   // Output FSM: IDLE launches the next byte, HOLD enforces the inter-strobe gap.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      dat_d   = dat_q;
      ctl_d   = ctl_q;
      pop_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop_c   = 1'b1;
               dat_d   = pop_data;
               ctl_d   = ~ctl_q;
               hold_d  = CNT_W'(GAP);
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q <= CNT_W'(1)) begin
               hold_d  = '0;
               state_d = ST_IDLE;
            end else begin
               hold_d = hold_q - CNT_W'(1);
            end
         end
      endcase
   end

   // State, output and round-robin registers; reset leaves requester 0 first in line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         dat_q   <= '0;
         ctl_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         dat_q   <= dat_d;
         ctl_q   <= ctl_d;
         last_q  <= last_d;
      end
   end

   assign out_dat = dat_q;
   assign out_ctl = ctl_q;
   assign busy    = (count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_out_arb.sv
// Scoreboard bench for out_arb: queue-based reference model plus a long-gap instance.
module tb_out_arb;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned GAP    = 2;
   localparam int unsigned GAP_B  = 15;
   localparam int          PERIOD = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = '0, req1_data = '0;
   logic       req0_ready, req1_ready;
   logic [7:0] out_dat;
   logic       out_ctl, busy;

   logic       b_v0 = 1'b0, b_v1 = 1'b0;
   logic [7:0] b_d0 = '0, b_d1 = '0;
   logic       b_r0, b_r1;
   logic [7:0] b_od;
   logic       b_oc, b_busy;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: FIFO contents, cycles left until the output port is free, last served.
   logic [7:0] fq[$];
   int         m_cool = 0;
   int         m_last = 1;

   // Scoreboard: expected bytes in order, expected toggle edge times.
   logic [7:0] sb_dat[$];
   time        sb_t[$];
   logic [7:0] emit_log[$];

   logic [7:0] b_log[$];
   time        b_tlog[$];

   out_arb #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .out_dat(out_dat), .out_ctl(out_ctl), .busy(busy)
   );

   out_arb #(.DEPTH(DEPTH), .GAP(GAP_B)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
      .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
      .out_dat(b_od), .out_ctl(b_oc), .busy(b_busy)
   );

   always #(PERIOD/2) clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_grant(input logic a0, input logic a1);
      if (a0 && !a1) return 0;
      if (a1 && !a0) return 1;
      return (m_last == 0) ? 1 : 0;
   endfunction

   // One clock of stimulus: drive on negedge, check readies/busy, advance the model at posedge.
   task automatic step(input logic a0, input logic [7:0] x0, input logic a1, input logic [7:0] x1,
                       output logic acc0, output logic acc1);
      logic full_m, er0, er1;
      int   g;
      logic [7:0] b;
      @(negedge clk);
      req0_valid = a0; req0_data = x0;
      req1_valid = a1; req1_data = x1;
      #1;
      full_m = (fq.size() == DEPTH);
      g      = rr_grant(a0, a1);
      er0    = !full_m && (g == 0);
      er1    = !full_m && (g == 1);
      chk("req0_ready", 32'(req0_ready), 32'(er0));
      chk("req1_ready", 32'(req1_ready), 32'(er1));
      chk("busy", 32'(busy), 32'((fq.size() != 0) || (m_cool != 0)));
      acc0 = a0 && er0;
      acc1 = a1 && er1;
      @(posedge clk);
      if (m_cool == 0 && fq.size() != 0) begin
         b = fq.pop_front();
         sb_t.push_back($time);
         m_cool = GAP;
      end else if (m_cool > 0) begin
         m_cool--;
      end
      if (acc0 || acc1) begin
         b = acc0 ? x0 : x1;
         fq.push_back(b);
         sb_dat.push_back(b);
         m_last = acc0 ? 0 : 1;
      end
   endtask

   task automatic idle(input int n);
      logic a0, a1;
      repeat (n) step(1'b0, 8'h00, 1'b0, 8'h00, a0, a1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
      #1;
      chk("rst_out_dat", 32'(out_dat), 32'h00);
      chk("rst_out_ctl", 32'(out_ctl), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_b_busy", 32'(b_busy), 32'h0);
      fq.delete(); sb_dat.delete(); sb_t.delete();
      m_cool = 0; m_last = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor for the main instance: a toggle pops the scoreboard, otherwise out_dat must hold.
   initial begin
      logic prev_ctl = 1'b0;
      logic [7:0] last_od = 8'h00;
      time t_edge, t_prev = 0;
      bit  have_prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_ctl = out_ctl; last_od = out_dat; have_prev = 1'b0;
            continue;
         end
         if (out_ctl !== prev_ctl) begin
            prev_ctl = out_ctl;
            t_edge = $time - (PERIOD/2 + 2);
            emit_log.push_back(out_dat);
            if (sb_dat.size() == 0 || sb_t.size() == 0) begin
               chk("unexpected_toggle", 32'(out_dat), 32'hFFFF_FFFF);
            end else begin
               chk("out_dat_order", 32'(out_dat), 32'(sb_dat.pop_front()));
               chk("toggle_time", 32'(t_edge), 32'(sb_t.pop_front()));
            end
            if (have_prev)
               chk("toggle_spacing_ok", 32'((t_edge - t_prev) >= (GAP + 1) * PERIOD), 32'h1);
            t_prev = t_edge; have_prev = 1'b1;
         end else begin
            chk("out_dat_stable", 32'(out_dat), 32'(last_od));
         end
         last_od = out_dat;
      end
   end

   // Monitor for the long-gap instance: capture every strobe and its edge time.
   initial begin
      logic bprev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            bprev = b_oc;
            continue;
         end
         if (b_oc !== bprev) begin
            bprev = b_oc;
            b_log.push_back(b_od);
            b_tlog.push_back($time - (PERIOD/2 + 2));
         end
      end
   end

   initial begin
      logic a0, a1;
      int   n0, n1, sent, guard;
      logic [7:0] x0, x1;
      time  t_acc0;

      // Reset state.
      do_reset();

      // Single byte on req0.
      step(1'b1, 8'h41, 1'b0, 8'h00, a0, a1);
      chk("single_accept", 32'(a0), 32'h1);
      idle(GAP + 4);

      // Both valid continuously: alternation starting with req0.
      do_reset();
      emit_log.delete();
      n0 = 0; n1 = 0;
      repeat (12) begin
         x0 = 8'(8'h30 + n0);
         x1 = 8'(8'h61 + n1);
         step(1'b1, x0, 1'b1, x1, a0, a1);
         if (a0) n0++;
         if (a1) n1++;
      end
      idle(40);
      chk("alt_count", 32'(emit_log.size() >= 4), 32'h1);
      if (emit_log.size() >= 4) begin
         chk("alt_0", 32'(emit_log[0]), 32'h30);
         chk("alt_1", 32'(emit_log[1]), 32'h61);
         chk("alt_2", 32'(emit_log[2]), 32'h31);
         chk("alt_3", 32'(emit_log[3]), 32'h62);
      end

      // Six back-to-back bytes from each requester in turn; covers full-with-pop cycles.
      for (int r = 0; r < 2; r++) begin
         sent = 0; guard = 0;
         while (sent < 6 && guard < 100) begin
            x0 = 8'(8'hA0 + 16 * r + sent);
            if (r == 0) step(1'b1, x0, 1'b0, 8'h00, a0, a1);
            else        step(1'b0, 8'h00, 1'b1, x0, a0, a1);
            if (a0 || a1) sent++;
            guard++;
         end
         chk("burst_sent", 32'(sent), 32'd6);
         idle(30);
      end

      // Randomized traffic.
      repeat (300) begin
         x0 = 8'($urandom_range(0, 255));
         x1 = 8'($urandom_range(0, 255));
         step(1'($urandom_range(0, 1)), x0, 1'($urandom_range(0, 1)), x1, a0, a1);
      end
      idle(40);
      chk("drain_dat", 32'(sb_dat.size()), 32'd0);
      chk("drain_t", 32'(sb_t.size()), 32'd0);

      // Reset during HOLD with three bytes queued: nothing may come out afterwards.
      sent = 0; guard = 0;
      while (sent < 5 && guard < 50) begin
         step(1'b1, 8'(8'hD0 + sent), 1'b0, 8'h00, a0, a1);
         if (a0) sent++;
         guard++;
      end
      chk("pre_reset_busy", 32'(busy), 32'h1);
      do_reset();
      idle(25);

      // Long-gap instance: 20 bytes from req1, strobes exactly GAP_B+1 cycles apart.
      sent = 0; guard = 0; t_acc0 = 0;
      while (sent < 20 && guard < 2000) begin
         @(negedge clk);
         b_v1 = 1'b1;
         b_d1 = 8'(8'hC0 + sent);
         #1;
         if (b_r1) begin
            @(posedge clk);
            if (sent == 0) t_acc0 = $time;
            sent++;
         end
         guard++;
      end
      @(negedge clk);
      b_v1 = 1'b0;
      chk("b_sent", 32'(sent), 32'd20);
      repeat (20 * (GAP_B + 1) + 20) @(negedge clk);
      chk("b_count", 32'(b_log.size()), 32'd20);
      chk("b_busy_end", 32'(b_busy), 32'h0);
      if (b_log.size() == 20) begin
         chk("b_first_latency", 32'(b_tlog[0]), 32'(t_acc0 + PERIOD));
         for (int i = 0; i < 20; i++) begin
            chk("b_data", 32'(b_log[i]), 32'(8'hC0 + i));
            if (i > 0) chk("b_spacing", 32'(b_tlog[i] - b_tlog[i-1]), 32'((GAP_B + 1) * PERIOD));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
